// File: rtl/icache_refill_arb.sv
// icache_refill_arb: round-robin arbiter that hands a single downstream refill
// port to one of NUM_REQ instruction-cache requesters, then routes BEAT_NUM
// response beats back to the owning requester.
// Optional watchdog: define ICACHE_REFILL_ARB_TIMEOUT_EN to abort a refill that
// stalls for TIMEOUT cycles without an accepted beat.
module icache_refill_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BEAT_NUM   = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          mem_req_vld,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_req_rdy,
  input  logic                          mem_rsp_vld,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_last,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned CNT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_NUM - 1);

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("icache_refill_arb: NUM_REQ must be at least 2");
  end
  if (BEAT_NUM < 1) begin : g_chk_beat_num
    $error("icache_refill_arb: BEAT_NUM must be at least 1");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("icache_refill_arb: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NUM_REQ-1:0]      ptr_q;
  logic [NUM_REQ-1:0]      owner_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    arb_en_q;

  logic [NUM_REQ-1:0]      ptr_mask;
  logic [NUM_REQ-1:0]      masked_req;
  logic [NUM_REQ-1:0]      pick;
  logic [NUM_REQ-1:0]      grant;
  logic                    grant_vld;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    beat_acc;
  logic                    last_beat;
  logic                    wd_hit;

  // Round-robin pick: lowest requester at/above the pointer, else lowest overall
  always_comb begin
    ptr_mask   = ~(ptr_q - NUM_REQ'(1));
    masked_req = req_vld & ptr_mask;
    pick       = (masked_req != '0) ? masked_req : req_vld;
    grant      = pick & (~pick + NUM_REQ'(1));
    grant_vld  = (state_q == IDLE) && arb_en_q && (req_vld != '0);
  end

  // Address mux for the one-hot grant
  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Beats only count while a refill owns the response channel
  always_comb begin
    beat_acc  = (state_q == RSP) && mem_rsp_vld;
    last_beat = beat_acc && (cnt_q == LAST_BEAT);
  end

  // Combinational handshake and response routing
  always_comb begin
    req_rdy  = grant_vld ? grant : '0;
    rsp_vld  = beat_acc ? owner_q : '0;
    rsp_data = mem_rsp_data;
    rsp_last = last_beat;
  end

`ifdef ICACHE_REFILL_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_q;

  // Watchdog fires when an active refill reaches the limit without a beat
  always_comb begin
    wd_hit      = (state_q != IDLE) && !beat_acc && (wd_q == WD_W'(TIMEOUT - 1));
    timeout_err = wd_hit;
  end

  // Watchdog counter: idle-held at zero, reset by each accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((state_q == IDLE) || beat_acc || wd_hit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  // No watchdog in this build
  always_comb begin
    wd_hit      = 1'b0;
    timeout_err = 1'b0;
  end
`endif

  // Refill FSM with its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= NUM_REQ'(1);
      owner_q      <= '0;
      cnt_q        <= '0;
      arb_en_q     <= 1'b0;
      mem_req_vld  <= 1'b0;
      mem_req_addr <= '0;
      busy         <= 1'b0;
    end else begin
      arb_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            state_q      <= REQ;
            owner_q      <= grant;
            mem_req_addr <= sel_addr;
            ptr_q        <= {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};
            mem_req_vld  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          if (wd_hit) begin
            state_q     <= IDLE;
            mem_req_vld <= 1'b0;
            busy        <= 1'b0;
          end else if (mem_req_rdy) begin
            state_q     <= RSP;
            cnt_q       <= '0;
            mem_req_vld <= 1'b0;
          end
        end
        RSP: begin
          if (wd_hit) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (beat_acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_req_vld <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_arb.sv
// Testbench for icache_refill_arb (NUM_REQ=4, BEAT_NUM=4, TIMEOUT=16).
// Timeout scenario adapts to ICACHE_REFILL_ARB_TIMEOUT_EN.
module tb_icache_refill_arb;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BN = 4;
  localparam int TO = 16;

  logic               clk;
  logic               rst_n;
  logic [NR-1:0]      req_vld;
  logic [NR*AW-1:0]   req_addr;
  logic [NR-1:0]      req_rdy;
  logic               mem_req_vld;
  logic [AW-1:0]      mem_req_addr;
  logic               mem_req_rdy;
  logic               mem_rsp_vld;
  logic [DW-1:0]      mem_rsp_data;
  logic [NR-1:0]      rsp_vld;
  logic [DW-1:0]      rsp_data;
  logic               rsp_last;
  logic               busy;
  logic               timeout_err;

  logic [AW-1:0]      addr_tab [NR];
  int                 n_checks;
  int                 n_fail;
  int                 model_ptr;

  icache_refill_arb #(
    .NUM_REQ   (NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BEAT_NUM  (BN),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_addr    (req_addr),
    .req_rdy     (req_rdy),
    .mem_req_vld (mem_req_vld),
    .mem_req_addr(mem_req_addr),
    .mem_req_rdy (mem_req_rdy),
    .mem_rsp_vld (mem_rsp_vld),
    .mem_rsp_data(mem_rsp_data),
    .rsp_vld     (rsp_vld),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter: first requester at or after the pointer, wrapping
  function automatic int model_grant(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (model_ptr + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_addr(input int idx, input logic [AW-1:0] a);
    addr_tab[idx] = a;
    req_addr[idx*AW +: AW] = a;
  endtask

  task automatic randomize_addrs();
    for (int i = 0; i < NR; i++) set_addr(i, AW'($urandom) & 32'hFFFF_FFC0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_vld = '0;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_ptr = 0;
  endtask

  // Drives one complete refill starting in IDLE; reports what it saw and how
  // many cycles deviated from the expected owner/address/handshake behaviour.
  task automatic run_refill(input logic [NR-1:0] vld, input int exp_idx,
                            input int rdy_delay, input int max_gap, input bit junk,
                            output logic [NR-1:0] obs_grant, output logic [AW-1:0] obs_addr,
                            output int bad, output int last_cnt);
    logic [NR-1:0] exp_oh;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] data;
    int            gap;
    bad = 0;
    last_cnt = 0;
    exp_oh = NR'(1) << exp_idx;
    exp_addr = addr_tab[exp_idx];
    obs_addr = '0;
    // arbitration cycle
    req_vld = vld;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = junk;
    #1;
    obs_grant = req_rdy;
    if (rsp_vld !== '0 || rsp_last !== 1'b0 || busy !== 1'b0) bad++;
    tick();
    // request phase with backpressure
    for (int i = 0; i <= rdy_delay; i++) begin
      mem_req_rdy = (i == rdy_delay);
      mem_rsp_vld = junk ? 1'($urandom) : 1'b0;
      #1;
      obs_addr = mem_req_addr;
      if (mem_req_vld !== 1'b1 || mem_req_addr !== exp_addr || req_rdy !== '0 ||
          rsp_vld !== '0 || rsp_last !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    mem_req_rdy = 1'b0;
    // response phase
    for (int b = 0; b < BN; b++) begin
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        mem_rsp_vld = 1'b0;
        #1;
        if (rsp_vld !== '0 || rsp_last !== 1'b0 || mem_req_vld !== 1'b0 || busy !== 1'b1) bad++;
        tick();
      end
      data = {$urandom, $urandom};
      mem_rsp_vld = 1'b1;
      mem_rsp_data = data;
      #1;
      if (rsp_vld !== exp_oh || rsp_data !== data || req_rdy !== '0) bad++;
      if (rsp_last === 1'b1) begin
        last_cnt++;
        if (b != BN - 1) bad++;
      end
      tick();
    end
    mem_rsp_vld = 1'b0;
    req_vld = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_vld = '1;
    mem_req_rdy = 1'b1;
    mem_rsp_vld = 1'b1;
    mem_rsp_data = '0;
    randomize_addrs();
    #12;
    tick();
    n_checks++; if (req_rdy !== '0) begin n_fail++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy); end
    n_checks++; if (mem_req_vld !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_vld: got %b expected 0", mem_req_vld); end
    n_checks++; if (mem_req_addr !== '0) begin n_fail++; $display("FAIL reset_mem_req_addr: got %h expected 0", mem_req_addr); end
    n_checks++; if (rsp_vld !== '0) begin n_fail++; $display("FAIL reset_rsp_vld: got %b expected 0000", rsp_vld); end
    n_checks++; if (rsp_last !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_last: got %b expected 0", rsp_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    req_vld = '0;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b0;
    rst_n = 1'b1;
    tick();
    model_ptr = 0;
  endtask

  task automatic test_single();
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    int bad, lc;
    set_addr(2, 32'h0000_1000);
    for (int r = 0; r < 3; r++) begin
      run_refill(4'b0100, 2, 0, r, 1'b0, g, a, bad, lc);
      n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL single_grant[%0d]: got %b expected 0100", r, g); end
      n_checks++; if (a !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr[%0d]: got %h expected 00001000", r, a); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_protocol[%0d]: got %0d bad cycles expected 0", r, bad); end
      n_checks++; if (lc !== 1) begin n_fail++; $display("FAIL single_last[%0d]: got %0d expected 1", r, lc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after[%0d]: got %b expected 0", r, busy); end
      model_ptr = 3;
    end
  endtask

  task automatic test_contention();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    int bad, lc;
    apply_reset();
    randomize_addrs();
    for (int k = 0; k < 5; k++) begin
      run_refill(4'b1111, exp_order[k], 1, 1, 1'b0, g, a, bad, lc);
      n_checks++; if (g !== (NR'(1) << exp_order[k])) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b expected requester %0d", k, g, exp_order[k]); end
      n_checks++; if (bad !== 0 || lc !== 1) begin n_fail++; $display("FAIL contention_protocol[%0d]: got bad=%0d last=%0d expected 0/1", k, bad, lc); end
    end
    model_ptr = 1;
  endtask

  task automatic test_wrap();
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    int bad, lc;
    run_refill(4'b0010, 1, 0, 0, 1'b0, g, a, bad, lc);
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL wrap_setup: got %b expected 0010", g); end
    model_ptr = 2;
    run_refill(4'b0011, 0, 0, 0, 1'b0, g, a, bad, lc);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant: got %b expected 0001", g); end
    n_checks++; if (a !== addr_tab[0]) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", a, addr_tab[0]); end
    model_ptr = 1;
    run_refill(4'b1111, 1, 0, 0, 1'b0, g, a, bad, lc);
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL wrap_pointer_after: got %b expected 0010", g); end
    model_ptr = 2;
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    int bad, lc, exp;
    randomize_addrs();
    exp = model_grant(4'b1000);
    run_refill(4'b1000, exp, 5, 0, 1'b0, g, a, bad, lc);
    n_checks++; if (g !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b expected 1000", g); end
    n_checks++; if (a !== addr_tab[3]) begin n_fail++; $display("FAIL bp_addr: got %h expected %h", a, addr_tab[3]); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d bad cycles expected 0", bad); end
    model_ptr = 0;
  endtask

  task automatic test_dropped_beats();
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    int bad, lc, exp;
    exp = model_grant(4'b0110);
    run_refill(4'b0110, exp, 3, 2, 1'b1, g, a, bad, lc);
    n_checks++; if (g !== (NR'(1) << exp)) begin n_fail++; $display("FAIL drop_grant: got %b expected requester %0d", g, exp); end
    n_checks++; if (bad !== 0 || lc !== 1) begin n_fail++; $display("FAIL drop_beats: got bad=%0d last=%0d expected 0/1", bad, lc); end
    model_ptr = (exp + 1) % NR;
  endtask

  task automatic test_random();
    logic [NR-1:0] g;
    logic [NR-1:0] v;
    logic [AW-1:0] a;
    int bad, lc, exp, idle_bad, ngap;
    for (int it = 0; it < 40; it++) begin
      randomize_addrs();
      ngap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      idle_bad = 0;
      for (int k = 0; k < ngap; k++) begin
        req_vld = '0;
        mem_rsp_vld = 1'($urandom);
        #1;
        if (req_rdy !== '0 || busy !== 1'b0 || rsp_vld !== '0 || mem_req_vld !== 1'b0) idle_bad++;
        tick();
      end
      mem_rsp_vld = 1'b0;
      if (ngap > 0) begin
        n_checks++; if (idle_bad !== 0) begin n_fail++; $display("FAIL rand_idle[%0d]: got %0d bad cycles expected 0", it, idle_bad); end
      end
      v = NR'($urandom_range(1, 15));
      exp = model_grant(v);
      run_refill(v, exp, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), g, a, bad, lc);
      n_checks++; if (g !== (NR'(1) << exp)) begin n_fail++; $display("FAIL rand_grant[%0d]: req %b got %b expected requester %0d", it, v, g, exp); end
      n_checks++; if (a !== addr_tab[exp]) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", it, a, addr_tab[exp]); end
      n_checks++; if (bad !== 0 || lc !== 1) begin n_fail++; $display("FAIL rand_protocol[%0d]: got bad=%0d last=%0d expected 0/1", it, bad, lc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy_after[%0d]: got %b expected 0", it, busy); end
      model_ptr = (exp + 1) % NR;
    end
  endtask

  task automatic test_reset_mid_rsp();
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    int bad, lc;
    req_vld = 4'b0100;
    mem_req_rdy = 1'b0;
    #1;
    tick();
    req_vld = '0;
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b1;
    tick();
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrsp_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    req_vld = 4'b1111;
    mem_req_rdy = 1'b1;
    mem_rsp_vld = 1'b1;
    #1;
    n_checks++; if ({req_rdy, rsp_vld} !== '0) begin n_fail++; $display("FAIL midrsp_vectors: got %b/%b expected 0000/0000", req_rdy, rsp_vld); end
    n_checks++; if ({mem_req_vld, rsp_last, busy, timeout_err} !== 4'b0000) begin n_fail++; $display("FAIL midrsp_flags: got %b expected 0000", {mem_req_vld, rsp_last, busy, timeout_err}); end
    n_checks++; if (mem_req_addr !== '0) begin n_fail++; $display("FAIL midrsp_addr: got %h expected 0", mem_req_addr); end
    tick();
    tick();
    req_vld = '0;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    n_checks++; if (busy !== 1'b0 || mem_req_vld !== 1'b0) begin n_fail++; $display("FAIL midrsp_no_replay: got busy=%b mem_req_vld=%b expected 0/0", busy, mem_req_vld); end
    model_ptr = 0;
    run_refill(4'b1111, 0, 0, 0, 1'b0, g, a, bad, lc);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL midrsp_regrant: got %b expected 0001", g); end
    model_ptr = 1;
  endtask

  task automatic test_timeout();
    logic [NR-1:0] oh;
    int pulses, idle_seen, lasts;
    oh = NR'(1) << model_ptr;
    req_vld = oh;
    mem_req_rdy = 1'b0;
    #1;
    n_checks++; if (req_rdy !== oh) begin n_fail++; $display("FAIL to_grant: got %b expected %b", req_rdy, oh); end
    tick();
    req_vld = '0;
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    pulses = 0;
    idle_seen = 0;
    lasts = 0;
    for (int c = 0; c < TO + 4; c++) begin
      #1;
      if (timeout_err === 1'b1) pulses++;
      if (rsp_last === 1'b1) lasts++;
      if (busy !== 1'b1) idle_seen++;
      tick();
    end
`ifdef ICACHE_REFILL_ARB_TIMEOUT_EN
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL to_pulse: got %0d pulses expected 1", pulses); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy=%b expected 0", busy); end
    n_checks++; if (lasts !== 0) begin n_fail++; $display("FAIL to_no_last: got %0d expected 0", lasts); end
`else
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL to_disabled_pulse: got %0d pulses expected 0", pulses); end
    n_checks++; if (idle_seen !== 0) begin n_fail++; $display("FAIL to_disabled_busy: got %0d idle cycles expected 0", idle_seen); end
    for (int b = 0; b < BN; b++) begin
      mem_rsp_vld = 1'b1;
      mem_rsp_data = {$urandom, $urandom};
      #1;
      if (rsp_last === 1'b1) lasts++;
      tick();
    end
    mem_rsp_vld = 1'b0;
    n_checks++; if (lasts !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_disabled_finish: got last=%0d busy=%b expected 1/0", lasts, busy); end
`endif
    model_ptr = (model_ptr + 1) % NR;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_ptr = 0;
    req_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_backpressure();
    test_dropped_beats();
    test_random();
    test_reset_mid_rsp();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
